// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: PC register -> imem valid/ready -> decode valid/ready, with redirects.
// Optional misaligned-PC fault handling is enabled by defining IFETCH_ALIGN_CHECK_EN.
module ifetch_ctrl #(
  parameter int DATA_W  = 32,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [31:0]       pc_in,
  output logic [31:0]       pc_next,
  output logic              pc_ena,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              fetch_fault
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_next_q, pc_next_d;
  logic                pc_ena_q, pc_ena_d;
  logic                imem_req_q, imem_req_d;
  logic [31:0]         imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [31:0]         instr_pc_q, instr_pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic                fault_q, fault_d;
  logic                start_fetch;
  logic [31:0]         fetch_pc;

  // When the PC register is being written on this very edge, pc_in still shows the
  // old value; take the value being written so the fetch uses the updated PC.
  assign fetch_pc = pc_ena_q ? pc_next_q : pc_in;

  always_comb begin
    state_d       = state_q;
    pc_next_d     = pc_next_q;
    pc_ena_d      = 1'b0;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    start_fetch   = 1'b0;

    if (redirect) begin
      pc_next_d     = redirect_pc;
      pc_ena_d      = 1'b1;
      instr_valid_d = 1'b0;
      imem_req_d    = 1'b0;
      fault_d       = 1'b0;
      state_d       = FLUSH;
    end else begin
      unique case (state_q)
        IDLE: start_fetch = run && !fault_q;
        REQ: begin
          if (imem_ready) begin
            instr_d       = imem_rdata;
            instr_pc_d    = imem_addr_q;
            instr_valid_d = 1'b1;
            pc_next_d     = imem_addr_q + 32'(PC_STEP);
            pc_ena_d      = 1'b1;
            imem_req_d    = 1'b0;
            state_d       = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid_d = 1'b0;
            start_fetch   = run;
            if (!run) state_d = IDLE;
          end
        end
        FLUSH: begin
          start_fetch = run;
          if (!run) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (start_fetch) begin
`ifdef IFETCH_ALIGN_CHECK_EN
        if (fetch_pc[1:0] != 2'b00) begin
          fault_d    = 1'b1;
          imem_req_d = 1'b0;
          state_d    = IDLE;
        end else begin
          imem_req_d  = 1'b1;
          imem_addr_d = fetch_pc;
          state_d     = REQ;
        end
`else
        imem_req_d  = 1'b1;
        imem_addr_d = fetch_pc & 32'hFFFF_FFFC;
        state_d     = REQ;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_next_q     <= '0;
      pc_ena_q      <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_next_q     <= pc_next_d;
      pc_ena_q      <= pc_ena_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  assign pc_next     = pc_next_q;
  assign pc_ena      = pc_ena_q;
  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_fault = fault_q;

endmodule
